// File: rtl/cy_tlb_bank.sv
// cy_tlb_bank: pipelined set-associative TLB bank.
//   Lookup:   req_valid/req_ready/req_vaddr/req_read/req_tag in,
//             resp_valid/resp_ready/resp_hit/resp_multi/resp_paddr/resp_tag out.
//             Minimum latency 3, in-order, at most RESP_DEPTH lookups in flight.
//   Write:    wr_en/wr_index/wr_way/wr_data; writes are dropped while flushing.
//   Flush:    flush_req pulse sweeps every set to zero; flush_busy while active.
//   Counters: hit_count/miss_count, saturating; cnt_clr clears them.

// One way: a 2-cycle RAM (registered address from the bank pipeline plus a
// registered output) and the hit compare for that way.
module cy_tlb_way #(
  parameter int ORDER     = 10,
  parameter int PAGE_BITS = 12,
  parameter int PA_BITS   = 36
) (
  input  logic                         clk,
  input  logic                         we_i,
  input  logic [ORDER-1:0]             widx_i,
  input  logic [63:0]                  wdata_i,
  input  logic [ORDER-1:0]             ridx_i,
  input  logic [63:0]                  va_i,
  input  logic                         rd_i,
  output logic                         hit_o,
  output logic [PA_BITS-PAGE_BITS-1:0] pfn_o
);
  logic [63:0] mem [0:(1<<ORDER)-1];
  logic [63:0] dout_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[widx_i] <= wdata_i;
    dout_q <= mem[ridx_i];
  end

  assign hit_o = dout_q[0] && (rd_i ? dout_q[1] : dout_q[2]) &&
                 (va_i[63:48] == 16'h0) &&
                 (dout_q[63:16+PAGE_BITS] == va_i[47:PAGE_BITS]);
  assign pfn_o = dout_q[PA_BITS-9:PAGE_BITS-8];

  logic unused_bits;
  assign unused_bits = ^{dout_q, va_i};
endmodule

module cy_tlb_bank #(
  parameter int ORDER      = 10,
  parameter int PAGE_BITS  = 12,
  parameter int WAYS       = 4,
  parameter int PA_BITS    = 36,
  parameter int RESP_DEPTH = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    wr_en,
  input  logic [ORDER-1:0]                        wr_index,
  input  logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] wr_way,
  input  logic [63:0]                             wr_data,
  input  logic                                    flush_req,
  output logic                                    flush_busy,
  input  logic                                    req_valid,
  output logic                                    req_ready,
  input  logic [63:0]                             req_vaddr,
  input  logic                                    req_read,
  input  logic [7:0]                              req_tag,
  output logic                                    resp_valid,
  input  logic                                    resp_ready,
  output logic                                    resp_hit,
  output logic                                    resp_multi,
  output logic [63:0]                             resp_paddr,
  output logic [7:0]                              resp_tag,
  input  logic                                    cnt_clr,
  output logic [31:0]                             hit_count,
  output logic [31:0]                             miss_count
);
  localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PFN_W = PA_BITS - PAGE_BITS;
  localparam int CW    = $clog2(RESP_DEPTH + 1);
  localparam int PW    = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [ORDER-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_SETTLE} fl_state_e;
  typedef struct packed {logic [63:0] va; logic rd; logic [7:0] tag;} req_t;
  typedef struct packed {logic hit; logic multi; logic [63:0] pa; logic [7:0] tag;} resp_t;

  // ---------------- flush sequencer ----------------
  fl_state_e        state_q, state_d;
  logic [ORDER-1:0] idx_q, idx_d;
  logic             settle_q, settle_d;
  logic             sweep;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      settle_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    unique case (state_q)
      ST_IDLE: if (flush_req) begin
        state_d = ST_SWEEP;
        idx_d   = '0;
      end
      ST_SWEEP: begin
        idx_d = idx_q + ORDER'(1);
        if (idx_q == LAST_IDX) begin
          state_d  = ST_SETTLE;
          settle_d = 1'b0;
        end
      end
      ST_SETTLE: begin
        settle_d = 1'b1;
        if (settle_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sweep      = (state_q == ST_SWEEP);
  assign flush_busy = (state_q != ST_IDLE);

  // ---------------- write port ----------------
  // Writes land in the RAM one cycle late so that a lookup accepted in the
  // same cycle as the write (which reads the RAM one cycle later) still sees
  // the old entry. The two SETTLE cycles cover the last delayed sweep write.
  logic             wr_vld_q, wr_all_q;
  logic [WW-1:0]    wr_way_q;
  logic [ORDER-1:0] wr_idx_q;
  logic [63:0]      wr_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_vld_q <= 1'b0;
    else     wr_vld_q <= sweep || (wr_en && !flush_busy);
  end

  always_ff @(posedge clk) begin
    wr_all_q  <= sweep;
    wr_way_q  <= wr_way;
    wr_idx_q  <= sweep ? idx_q : wr_index;
    wr_data_q <= sweep ? 64'h0 : wr_data;
  end

  // ---------------- lookup pipeline ----------------
  // Stage 0 holds the RAM read address, stage 1 sees the RAM output.
  logic       [1:0] vld_pipe_q;
  req_t       [1:0] req_pipe_q;
  logic             accept, push, pop;
  logic [CW:0]      in_flight;
  logic [CW-1:0]    cnt_q;

  assign in_flight = {1'b0, cnt_q} + (CW+1)'(vld_pipe_q[0]) + (CW+1)'(vld_pipe_q[1]);
  assign req_ready = !flush_busy && (in_flight < (CW+1)'(RESP_DEPTH));
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe_q <= '0;
    else     vld_pipe_q <= {vld_pipe_q[0], accept};
  end

  always_ff @(posedge clk) begin
    req_pipe_q[0] <= {req_vaddr, req_read, req_tag};
    req_pipe_q[1] <= req_pipe_q[0];
  end

  logic [WAYS-1:0]             way_hit;
  logic [WAYS-1:0][PFN_W-1:0]  way_pfn;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cy_tlb_way #(.ORDER(ORDER), .PAGE_BITS(PAGE_BITS), .PA_BITS(PA_BITS)) u_way (
      .clk    (clk),
      .we_i   (wr_vld_q && (wr_all_q || (wr_way_q == WW'(w)))),
      .widx_i (wr_idx_q),
      .wdata_i(wr_data_q),
      .ridx_i (req_pipe_q[0].va[PAGE_BITS+ORDER-1:PAGE_BITS]),
      .va_i   (req_pipe_q[1].va),
      .rd_i   (req_pipe_q[1].rd),
      .hit_o  (way_hit[w]),
      .pfn_o  (way_pfn[w])
    );
  end

  // Scan from the top way down so the lowest hitting way's PFN wins.
  logic             hit_any, multi;
  logic [PFN_W-1:0] pfn_sel;
  logic [63:0]      pa;
  resp_t            resp_in;

  always_comb begin
    hit_any = 1'b0;
    multi   = 1'b0;
    pfn_sel = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_hit[w]) begin
        multi   = multi | hit_any;
        hit_any = 1'b1;
        pfn_sel = way_pfn[w];
      end
    end
    pa = 64'h0;
    if (hit_any) begin
      pa[PAGE_BITS-1:0]       = req_pipe_q[1].va[PAGE_BITS-1:0];
      pa[PA_BITS-1:PAGE_BITS] = pfn_sel;
    end
  end

  assign resp_in = {hit_any, multi, pa, req_pipe_q[1].tag};

  // ---------------- response buffer ----------------
  // Credits guarantee space, so push never checks for full.
  resp_t         buf_q [RESP_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  resp_t         head;

  function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push = vld_pipe_q[1];
  assign pop  = resp_valid && resp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= ptr_nxt(wptr_q);
      if (pop)  rptr_q <= ptr_nxt(rptr_q);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) buf_q[wptr_q] <= resp_in;
  end

  assign head       = buf_q[rptr_q];
  assign resp_valid = (cnt_q != '0);
  assign resp_hit   = resp_valid && head.hit;
  assign resp_multi = resp_valid && head.multi;
  assign resp_paddr = resp_valid ? head.pa  : 64'h0;
  assign resp_tag   = resp_valid ? head.tag : 8'h0;

  // ---------------- statistics ----------------
  logic [31:0] hit_q, miss_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (cnt_clr) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (push) begin
      if (resp_in.hit) begin
        if (hit_q != '1) hit_q <= hit_q + 32'd1;
      end else begin
        if (miss_q != '1) miss_q <= miss_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
endmodule

// File: tb/tb_cy_tlb_bank.sv
module tb_cy_tlb_bank;
  localparam int ORDER = 10, PAGE_BITS = 12, WAYS = 4, PA_BITS = 36, RESP_DEPTH = 4;
  localparam int NSETS = 1 << ORDER;

  logic        clk = 1'b0, rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [ORDER-1:0] wr_index = '0;
  logic [1:0]  wr_way = '0;
  logic [63:0] wr_data = '0;
  logic        flush_req = 1'b0, flush_busy;
  logic        req_valid = 1'b0, req_ready, req_read = 1'b1;
  logic [63:0] req_vaddr = '0;
  logic [7:0]  req_tag = '0;
  logic        resp_valid, resp_ready = 1'b1, resp_hit, resp_multi;
  logic [63:0] resp_paddr;
  logic [7:0]  resp_tag;
  logic        cnt_clr = 1'b0;
  logic [31:0] hit_count, miss_count;

  always #5 clk = ~clk;

  cy_tlb_bank #(.ORDER(ORDER), .PAGE_BITS(PAGE_BITS), .WAYS(WAYS), .PA_BITS(PA_BITS),
                .RESP_DEPTH(RESP_DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_index(wr_index), .wr_way(wr_way),
    .wr_data(wr_data), .flush_req(flush_req), .flush_busy(flush_busy),
    .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
    .req_read(req_read), .req_tag(req_tag), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_hit(resp_hit), .resp_multi(resp_multi),
    .resp_paddr(resp_paddr), .resp_tag(resp_tag), .cnt_clr(cnt_clr),
    .hit_count(hit_count), .miss_count(miss_count));

  typedef struct packed {logic hit; logic multi; logic [63:0] pa; logic [7:0] tag;} exp_t;
  typedef struct {logic [63:0] va; logic rd; logic hit; logic multi; logic [63:0] pa;} vec_t;

  int n_cmp = 0, n_bad = 0;
  logic [63:0] mmem [WAYS][NSETS];
  exp_t sbq [$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] mk_entry(input longint unsigned vpn, input longint unsigned pfn,
                                           input logic [2:0] perm);
    return (vpn << (16 + PAGE_BITS)) | (pfn << (PAGE_BITS - 8)) | 64'(perm);
  endfunction

  // Reference: evaluate every way from the entry format rules directly.
  function automatic exp_t model_lookup(input logic [63:0] va, input logic rd, input logic [7:0] tg);
    exp_t r;
    longint unsigned e, vpn, pfn;
    int idx, nh;
    r = '0; r.tag = tg; nh = 0;
    idx = int'((va >> PAGE_BITS) % NSETS);
    vpn = (va % (64'd1 << 48)) >> PAGE_BITS;
    for (int w = 0; w < WAYS; w++) begin
      e = mmem[w][idx];
      if (e[0] && (rd ? e[1] : e[2]) && (va >> 48) == 0 && (e >> (16 + PAGE_BITS)) == vpn) begin
        nh++;
        if (nh == 1) begin
          pfn  = (e >> (PAGE_BITS - 8)) % (64'd1 << (PA_BITS - PAGE_BITS));
          r.pa = pfn * (64'd1 << PAGE_BITS) + va % (64'd1 << PAGE_BITS);
        end
      end
    end
    r.hit = (nh > 0); r.multi = (nh > 1);
    return r;
  endfunction

  task automatic wr_entry(input int w, input int idx, input logic [63:0] d);
    wr_en = 1'b1; wr_way = 2'(w); wr_index = ORDER'(idx); wr_data = d;
    mmem[w][idx] = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Issue one lookup and wait until its response is at the head (not yet popped).
  task automatic lookup(input logic [63:0] va, input logic rd, input logic [7:0] tg, output int lat);
    int g;
    req_vaddr = va; req_read = rd; req_tag = tg; req_valid = 1'b1;
    g = 0;
    while (!req_ready && g < 2000) begin tick(); g++; end
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 50) begin tick(); lat++; end
  endtask

  task automatic wait_resp();
    int g;
    g = 0;
    while (!resp_valid && g < 50) begin tick(); g++; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[7];
    int lat, n, bad, acc, exp_hits, exp_miss, mhits, mmiss, g;
    logic [63:0] va;
    exp_t e;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_flush_busy", flush_busy, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);
    chk("rst_resp_fields", {resp_hit, resp_multi, resp_paddr, resp_tag}, 0);
    rst = 1'b0;
    tick();
    chk("rst_req_ready", req_ready, 1);

    // RAM is not cleared by reset: flush before use.
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    g = 0;
    while (flush_busy && g < 5000) begin tick(); g++; end
    for (int w = 0; w < WAYS; w++) for (int i = 0; i < NSETS; i++) mmem[w][i] = '0;

    // ---- table-driven lookups ----
    wr_entry(2, 5, mk_entry(64'h5000 >> 12, 24'hABCDE, 3'b011));
    wr_entry(1, 7, mk_entry(7, 24'h111, 3'b111));
    wr_entry(3, 7, mk_entry(7, 24'h333, 3'b111));
    vt[0] = '{va: 64'h0000_0000_0000_5123, rd: 1'b1, hit: 1'b1, multi: 1'b0, pa: 64'hABCDE123};
    vt[1] = '{va: 64'h0000_0000_0000_5123, rd: 1'b0, hit: 1'b0, multi: 1'b0, pa: 64'h0};
    vt[2] = '{va: 64'h0001_0000_0000_5123, rd: 1'b1, hit: 1'b0, multi: 1'b0, pa: 64'h0};
    vt[3] = '{va: 64'h0000_0000_0000_7FFF, rd: 1'b0, hit: 1'b1, multi: 1'b1, pa: 64'h111FFF};
    vt[4] = '{va: 64'h0000_0000_0000_7000, rd: 1'b1, hit: 1'b1, multi: 1'b1, pa: 64'h111000};
    vt[5] = '{va: 64'h0000_4000_0000_5123, rd: 1'b1, hit: 1'b0, multi: 1'b0, pa: 64'h0};
    vt[6] = '{va: 64'h0000_0000_0000_6ABC, rd: 1'b1, hit: 1'b0, multi: 1'b0, pa: 64'h0};
    exp_hits = 0; exp_miss = 0;
    for (int i = 0; i < 7; i++) begin
      lookup(vt[i].va, vt[i].rd, 8'(i), lat);
      if (vt[i].hit) exp_hits++; else exp_miss++;
      chk($sformatf("vec%0d_latency", i), lat, 3);
      chk($sformatf("vec%0d_hit", i), resp_hit, vt[i].hit);
      chk($sformatf("vec%0d_multi", i), resp_multi, vt[i].multi);
      chk($sformatf("vec%0d_paddr", i), resp_paddr, vt[i].pa);
      chk($sformatf("vec%0d_tag", i), resp_tag, i);
      chk($sformatf("vec%0d_hit_count", i), hit_count, exp_hits);
      chk($sformatf("vec%0d_miss_count", i), miss_count, exp_miss);
      tick();
    end

    // ---- write/lookup ordering ----
    wr_en = 1'b1; wr_way = 2'd0; wr_index = ORDER'(9); wr_data = mk_entry(9, 24'h999, 3'b011);
    req_valid = 1'b1; req_vaddr = 64'h9ABC; req_read = 1'b1; req_tag = 8'h50;
    tick();
    mmem[0][9] = wr_data;
    wr_en = 1'b0; req_tag = 8'h51;
    tick();
    req_valid = 1'b0;
    wait_resp();
    chk("order_same_cycle_hit", {resp_valid, resp_hit, resp_tag}, {1'b1, 1'b0, 8'h50});
    tick();
    wait_resp();
    chk("order_next_cycle_hit", {resp_valid, resp_hit, resp_tag}, {1'b1, 1'b1, 8'h51});
    chk("order_next_cycle_paddr", resp_paddr, 64'h999ABC);
    tick();

    // ---- backpressure / credits ----
    resp_ready = 1'b0; acc = 0;
    for (int c = 0; c < 6; c++) begin
      req_valid = 1'b1; req_vaddr = 64'h5123; req_read = 1'b1; req_tag = 8'(acc);
      if (req_ready) acc++;
      tick();
    end
    req_valid = 1'b0;
    chk("bp_accepted", acc, 4);
    chk("bp_ready_low", req_ready, 0);
    repeat (5) tick();
    chk("bp_ready_still_low", req_ready, 0);
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_resp();
      chk($sformatf("bp_resp%0d_tag", k), {resp_valid, resp_tag}, {1'b1, 8'(k)});
      chk($sformatf("bp_resp%0d_paddr", k), resp_paddr, 64'hABCDE123);
      tick();
    end
    chk("bp_drained", resp_valid, 0);
    chk("bp_ready_back", req_ready, 1);

    // ---- randomized traffic vs reference model ----
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    chk("clr_counts", {hit_count, miss_count}, 0);
    mhits = 0; mmiss = 0;
    for (int c = 0; c < 3000; c++) begin
      va = (64'($urandom % 16) << PAGE_BITS) | 64'($urandom % 4096);
      if ($urandom % 16 == 0) va[48 + ($urandom % 16)] = 1'b1;
      req_valid = ($urandom % 3) != 0;
      req_vaddr = va; req_read = 1'($urandom); req_tag = 8'($urandom);
      wr_en = ($urandom % 4) == 0; wr_way = 2'($urandom); wr_index = ORDER'($urandom % 16);
      wr_data = mk_entry($urandom % 16, $urandom % (1 << 24), 3'($urandom));
      resp_ready = ($urandom % 4) != 0;
      chk("rnd_credit_ready", req_ready, sbq.size() < RESP_DEPTH);
      if (resp_valid && resp_ready) begin
        if (sbq.size() == 0) chk("rnd_unexpected_resp", resp_valid, 0);
        else begin
          e = sbq.pop_front();
          chk("rnd_resp", {resp_hit, resp_multi, resp_paddr, resp_tag}, e);
        end
      end
      if (req_valid && req_ready) begin
        e = model_lookup(va, req_read, req_tag);
        sbq.push_back(e);
        if (e.hit) mhits++; else mmiss++;
      end
      if (wr_en) mmem[wr_way][wr_index] = wr_data;
      tick();
    end
    req_valid = 1'b0; wr_en = 1'b0; resp_ready = 1'b1;
    g = 0;
    while (sbq.size() > 0 && g < 100) begin
      if (resp_valid) begin
        e = sbq.pop_front();
        chk("rnd_drain_resp", {resp_hit, resp_multi, resp_paddr, resp_tag}, e);
      end
      tick(); g++;
    end
    chk("rnd_drain_empty", sbq.size(), 0);
    chk("rnd_hit_count", hit_count, mhits);
    chk("rnd_miss_count", miss_count, mmiss);

    // ---- flush ----
    wr_entry(2, 5, mk_entry(5, 24'hABCDE, 3'b011));
    wr_entry(1, 7, mk_entry(7, 24'h111, 3'b111));
    wr_entry(3, 7, mk_entry(7, 24'h333, 3'b111));
    chk("pre_flush_busy", flush_busy, 0);
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    chk("flush_rise", flush_busy, 1);
    n = 0; bad = 0;
    while (flush_busy && n < 5000) begin
      if (req_ready) bad++;
      wr_en = (n == 3);
      wr_way = 2'd0; wr_index = '0; wr_data = mk_entry(0, 24'h777, 3'b111);
      flush_req = (n == 10);
      tick(); n++;
    end
    wr_en = 1'b0; flush_req = 1'b0;
    chk("flush_len", n, NSETS + 2);
    chk("flush_ready_low", bad, 0);
    for (int w = 0; w < WAYS; w++) for (int i = 0; i < NSETS; i++) mmem[w][i] = '0;
    for (int i = 0; i < 8; i++) begin
      va = (i < 7) ? vt[i].va : 64'h0123;
      lookup(va, 1'b1, 8'(i + 8'h80), lat);
      e = model_lookup(va, 1'b1, 8'(i + 8'h80));
      chk($sformatf("post_flush%0d", i), {resp_valid, resp_hit, resp_multi, resp_paddr, resp_tag},
          {1'b1, e});
      tick();
    end

    // ---- reset mid-sweep with two lookups in flight ----
    req_valid = 1'b1; req_vaddr = 64'h5123; req_read = 1'b1; req_tag = 8'hA0;
    tick();
    req_tag = 8'hA1; flush_req = 1'b1;
    tick();
    req_valid = 1'b0; flush_req = 1'b0;
    chk("mid_sweep_busy", flush_busy, 1);
    chk("pre_rst_miss_nonzero", miss_count != 0, 1);
    rst = 1'b1; #1;
    chk("rst2_flush_busy", flush_busy, 0);
    chk("rst2_resp_valid", resp_valid, 0);
    chk("rst2_counts", {hit_count, miss_count}, 0);
    tick(); tick();
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      if (resp_valid || flush_busy) bad++;
      tick();
    end
    chk("rst2_no_response", bad, 0);
    chk("rst2_req_ready", req_ready, 1);

    // ---- cnt_clr beats a same-cycle hit increment ----
    wr_entry(2, 5, mk_entry(5, 24'hABCDE, 3'b011));
    req_valid = 1'b1; req_vaddr = 64'h5123; req_read = 1'b1; req_tag = 8'hC0;
    tick();
    req_valid = 1'b0;
    tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_prio_resp", {resp_valid, resp_hit, resp_paddr}, {1'b1, 1'b1, 64'hABCDE123});
    chk("clr_prio_hit_count", hit_count, 0);
    tick();
    lookup(64'h5123, 1'b1, 8'hC1, lat);
    chk("clr_after_hit_count", hit_count, 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
